draw_sprite: RTL and testbench
==============================

# draw_sprite

Parametrised raster blitter that copies a W×H image (one of FRAMES stacked frames) from an external synchronous ROM to the 160×120 VGA framebuffer at a runtime origin. It emits one pixel per cycle with a plot strobe and supports optional transparent-colour skipping and off-screen clipping. It sits between the game FSM and the VGA adapter and serves both the full-screen background (W=160, H=120, origin 0,0) and animated sprites (Pac-Man, ghosts).

## Interface
- IMG_W, 160: image width in pixels, 1..160
- IMG_H, 120: image height in pixels, 1..120
- FRAMES, 1: frames stored back-to-back in ROM, 1..16
- COLOUR_W, 3: colour bits per pixel
- TRANSP_EN, 0: 1 = suppress plot for pixels equal to TRANSP
- TRANSP, 0: transparent colour value
- ADDR_W, 15: ROM address width; must satisfy 2^ADDR_W ≥ FRAMES·IMG_W·IMG_H

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin draw; sampled only in IDLE
- x0  in  8  origin column, latched on accepted start
- y0  in  7  origin row, latched on accepted start
- frame  in  4  frame index, latched on accepted start; values ≥ FRAMES are treated as 0
- rom_addr  out  ADDR_W  ROM read address
- rom_q  in  COLOUR_W  ROM data, valid one cycle after rom_addr
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- colour  out  COLOUR_W  pixel colour
- plot  out  1  write strobe for the VGA adapter
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the draw completes

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: busy=0. On start=1, latch x0/y0/frame, clear col and row, and go to RUN.
- RUN: each cycle, rom_addr = frame·IMG_W·IMG_H + row·IMG_W + col.
  - col increments; at col=IMG_W−1, col wraps to 0 and row increments.
  - When the address for (IMG_W−1, IMG_H−1) has been issued, go to FLUSH.
  - Exactly IMG_W·IMG_H addresses are issued, with no duplicates and no extra column or row.
- Pipeline register (1 stage): captures valid, col+x0 (9-bit) and row+y0 (8-bit) alongside each issued address.
- Output stage, the cycle after issue:
  - vga_x/vga_y take the registered coordinates, truncated.
  - colour = rom_q.
  - plot = valid AND x<160 AND y<120 AND NOT(TRANSP_EN AND rom_q==TRANSP).
- FLUSH: one cycle, so the final pixel is output. Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. done may coincide with an accepted start only on the following IDLE cycle.
- start while busy is ignored; it is not queued.
- Arithmetic: address products are computed at ADDR_W bits. The frame offset is a constant multiple, added once at latch time as a base register.

## Timing
- Reset (async) values: state=IDLE, rom_addr=0, vga_x=0, vga_y=0, colour=0, plot=0, busy=0, done=0, and all counters 0.
- Reset asserted mid-draw aborts immediately. No done pulse is produced, and the next draw needs a fresh start.
- start accepted at edge N:
  - first rom_addr is valid in cycle N+1.
  - first plot-qualified pixel appears in cycle N+2.
  - last pixel appears in cycle N+1+IMG_W·IMG_H.
  - done is high in cycle N+2+IMG_W·IMG_H.
- busy is high from cycle N+1 through the done cycle inclusive.
- plot is never asserted in IDLE or DONE.
- Clipped and transparent pixels still consume their cycle, so draw duration is independent of image content and position.
- vga_x/vga_y/colour hold their last values when plot=0.

## Structure
- Shared package draw_pkg:
  - SCREEN_W=160, SCREEN_H=120
  - state encoding for IDLE/RUN/FLUSH/DONE
  - the colour width default
- Sub-module raster_counter (parameters W, H): col/row counters with clear, enable and last-pixel flag. It is reused later by the screen-clear block.
- The ROM stays outside the block. Top level instantiates the existing background ROM and one ROM per sprite.

## Test plan
- Default params, start with x0=0, y0=0: 19200 plots, the first at (0,0) and the last at (159,119). Addresses run 0..19199 exactly once each, done arrives 19202 cycles after start, and no pixel has x=160.
- IMG_W=IMG_H=8, FRAMES=4, frame=2, x0=10, y0=20: rom_addr runs 128..191, plots cover (10..17, 20..27), done pulses once, and busy drops with done.
- 8×8, x0=156, y0=116: 16 plots, only for x in 156..159 and y in 116..119. The total cycle count equals the unclipped case.
- TRANSP_EN=1, TRANSP=0, ROM holding a checkerboard of 0/5: exactly 32 plots, all with colour=5.
- Pulse start again at cycle +5 mid-draw: ignored, with the address sequence and done timing unchanged.
- Assert resetn=0 at pixel 30, then release: all outputs read 0 immediately, no done is produced, and a new start draws correctly from (0,0).

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants for the VGA drawing blocks: screen geometry, FSM encoding and
// default colour width.
package draw_pkg;

   localparam int unsigned SCREEN_W     = 160;
   localparam int unsigned SCREEN_H     = 120;
   localparam int unsigned COLOUR_W_DEF = 3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_FLUSH = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Counter width for a 0..n-1 range; a 1-wide range still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster scan counter over a W x H grid with synchronous clear, enable
// and a flag marking the final (W-1, H-1) position.
module raster_counter
   import draw_pkg::*;
#(
   parameter int unsigned W = 160,
   parameter int unsigned H = 120,
   localparam int unsigned CW = cnt_width(W),
   localparam int unsigned RW = cnt_width(H)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          col_end;
   logic          row_end;

   assign col_end = (col_q == COL_MAX);
   assign row_end = (row_q == ROW_MAX);
   assign last    = col_end && row_end;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr) begin
         col_d = '0;
         row_d = '0;
      end else if (en) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col = col_q;
   assign row = row_q;

endmodule

// File: rtl/draw_sprite.sv
// Raster blitter: streams a W x H frame from an external synchronous ROM to the
// 160x120 framebuffer at a runtime origin, one pixel per cycle, with clipping.
module draw_sprite
   import draw_pkg::*;
#(
   parameter int unsigned IMG_W     = 160,
   parameter int unsigned IMG_H     = 120,
   parameter int unsigned FRAMES    = 1,
   parameter int unsigned COLOUR_W  = COLOUR_W_DEF,
   parameter bit          TRANSP_EN = 1'b0,
   parameter int unsigned TRANSP    = 0,
   parameter int unsigned ADDR_W    = 15
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic [7:0]          x0,
   input  logic [6:0]          y0,
   input  logic [3:0]          frame,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_q,
   output logic [7:0]          vga_x,
   output logic [6:0]          vga_y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CW = cnt_width(IMG_W);
   localparam int unsigned RW = cnt_width(IMG_H);

   localparam logic [ADDR_W-1:0]   FRAME_SZ   = ADDR_W'(IMG_W * IMG_H);
   localparam logic [ADDR_W-1:0]   ROW_STRIDE = ADDR_W'(IMG_W);
   localparam logic [COLOUR_W-1:0] TRANSP_C   = COLOUR_W'(TRANSP);

   state_t state_q, state_d;

   logic [7:0]        x0_q;
   logic [6:0]        y0_q;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [3:0]        frame_eff;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          last;
   logic          accept;
   logic          cnt_en;

   logic       pix_valid_q;
   logic [8:0] pix_x_q;
   logic [7:0] pix_y_q;

   logic [7:0]          x_hold_q;
   logic [6:0]          y_hold_q;
   logic [COLOUR_W-1:0] c_hold_q;
   logic                transp_hit;

   assign accept = (state_q == ST_IDLE) && start;
   assign cnt_en = (state_q == ST_RUN);

   // Out-of-range frame indices fall back to frame 0 rather than reading past the ROM.
   assign frame_eff = (32'(frame) < FRAMES) ? frame : 4'd0;
   assign base_d    = ADDR_W'(frame_eff) * FRAME_SZ;

   raster_counter #(
      .W (IMG_W),
      .H (IMG_H)
   ) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (accept),
      .en     (cnt_en),
      .col    (col),
      .row    (row),
      .last   (last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (last) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            x0_q   <= x0;
            y0_q   <= y0;
            base_q <= base_d;
         end
      end
   end

   assign rom_addr = base_q + ADDR_W'(row) * ROW_STRIDE + ADDR_W'(col);

   // Screen coordinates travel alongside the ROM read so they meet rom_q next cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
      end else begin
         pix_valid_q <= cnt_en;
         pix_x_q     <= {1'b0, x0_q} + 9'(col);
         pix_y_q     <= {1'b0, y0_q} + 8'(row);
      end
   end

   assign transp_hit = TRANSP_EN && (rom_q == TRANSP_C);
   assign plot = pix_valid_q && (pix_x_q < 9'(SCREEN_W)) && (pix_y_q < 8'(SCREEN_H))
                 && !transp_hit;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_hold_q <= '0;
         y_hold_q <= '0;
         c_hold_q <= '0;
      end else if (plot) begin
         x_hold_q <= pix_x_q[7:0];
         y_hold_q <= pix_y_q[6:0];
         c_hold_q <= rom_q;
      end
   end

   assign vga_x  = plot ? pix_x_q[7:0] : x_hold_q;
   assign vga_y  = plot ? pix_y_q[6:0] : y_hold_q;
   assign colour = plot ? rom_q        : c_hold_q;

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: an 8x8x4 transparent sprite instance and a full-screen
// background instance, each fed by a behavioural ROM and checked against a pixel list model.
module tb_draw_sprite;

   localparam int unsigned AW = 8;
   localparam int unsigned AH = 8;
   localparam int unsigned AF = 4;
   localparam int unsigned AP = AW * AH;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic       start_a, start_b;
   logic [7:0] x0;
   logic [6:0] y0;
   logic [3:0] frame;

   logic [7:0]  rom_addr_a;
   logic [2:0]  rom_q_a, colour_a;
   logic [7:0]  vga_x_a;
   logic [6:0]  vga_y_a;
   logic        plot_a, busy_a, done_a;

   logic [14:0] rom_addr_b;
   logic [2:0]  rom_q_b, colour_b;
   logic [7:0]  vga_x_b;
   logic [6:0]  vga_y_b;
   logic        plot_b, busy_b, done_b;

   logic [2:0] rom_a [256];
   logic [2:0] rom_b [32768];

   always_ff @(posedge clk) rom_q_a <= rom_a[rom_addr_a];
   always_ff @(posedge clk) rom_q_b <= rom_b[rom_addr_b];

   draw_sprite #(
      .IMG_W     (AW),
      .IMG_H     (AH),
      .FRAMES    (AF),
      .COLOUR_W  (3),
      .TRANSP_EN (1'b1),
      .TRANSP    (0),
      .ADDR_W    (8)
   ) u_dut_a (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start_a),
      .x0       (x0),
      .y0       (y0),
      .frame    (frame),
      .rom_addr (rom_addr_a),
      .rom_q    (rom_q_a),
      .vga_x    (vga_x_a),
      .vga_y    (vga_y_a),
      .colour   (colour_a),
      .plot     (plot_a),
      .busy     (busy_a),
      .done     (done_a)
   );

   draw_sprite u_dut_b (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start_b),
      .x0       (x0),
      .y0       (y0),
      .frame    (frame),
      .rom_addr (rom_addr_b),
      .rom_q    (rom_q_b),
      .vga_x    (vga_x_b),
      .vga_y    (vga_y_b),
      .colour   (colour_b),
      .plot     (plot_b),
      .busy     (busy_b),
      .done     (done_b)
   );

   int n_checks;
   int n_errors;

   logic        sel_b;
   logic [14:0] s_addr;
   logic [7:0]  s_x;
   logic [6:0]  s_y;
   logic [2:0]  s_col;
   logic        s_plot, s_busy, s_done;

   always_comb begin
      if (sel_b) begin
         s_addr = rom_addr_b;
         s_x    = vga_x_b;
         s_y    = vga_y_b;
         s_col  = colour_b;
         s_plot = plot_b;
         s_busy = busy_b;
         s_done = done_b;
      end else begin
         s_addr = 15'(rom_addr_a);
         s_x    = vga_x_a;
         s_y    = vga_y_a;
         s_col  = colour_a;
         s_plot = plot_a;
         s_busy = busy_a;
         s_done = done_a;
      end
   end

   // Last pixel plotted by the sprite instance, for the output-hold check.
   logic [7:0] last_x;
   logic [6:0] last_y;
   logic [2:0] last_c;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] rom_val(input bit b, input int a);
      return b ? rom_b[a] : rom_a[a];
   endfunction

   task automatic draw(input string nm, input bit b, input logic [7:0] px0,
                       input logic [6:0] py0, input logic [3:0] pf, input bit mid_start,
                       input int rst_at);
      int w, h, p, base, fe;
      int done_at, n_done, addr_bad, busy_bad, plot_bad, hold_bad, mism;
      int exp_q[$];
      int obs_q[$];
      w = b ? 160 : AW;
      h = b ? 120 : AH;
      p = w * h;
      fe = (b || int'(pf) >= AF) ? 0 : int'(pf);
      base = fe * p;
      // Expected plot list in raster order from the drawing rules.
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            int x, y, v;
            x = int'(px0) + c;
            y = int'(py0) + r;
            v = int'(rom_val(b, base + r * w + c));
            if (x < 160 && y < 120 && (b || v != 0)) exp_q.push_back((x << 16) | (y << 8) | v);
         end
      end
      sel_b = b;
      x0 = px0;
      y0 = py0;
      frame = pf;
      if (b) start_b = 1'b1;
      else start_a = 1'b1;
      done_at = -1;
      n_done = 0;
      addr_bad = 0;
      busy_bad = 0;
      plot_bad = 0;
      hold_bad = 0;
      mism = 0;
      for (int k = 1; k <= p + 3; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         if (mid_start && k == 5) begin
            x0 = ~px0;
            if (b) start_b = 1'b1;
            else start_a = 1'b1;
         end
         if (mid_start && k == 6) begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         if (k == rst_at) begin
            resetn = 1'b0;
            #1;
            check_eq({nm, ".rst_outs"}, {s_addr, s_x, s_y, s_col, s_plot, s_busy, s_done}, 0);
            repeat (2) begin
               @(negedge clk);
               n_done += int'(s_done);
            end
            resetn = 1'b1;
            repeat (4) begin
               @(negedge clk);
               n_done += int'(s_done) + int'(s_busy);
            end
            check_eq({nm, ".rst_no_done"}, n_done, 0);
            last_x = '0;
            last_y = '0;
            last_c = '0;
            return;
         end
         if (k <= p && s_addr !== 15'(base + k - 1)) addr_bad++;
         if (s_busy !== (k <= p + 2)) busy_bad++;
         if (s_done) begin
            n_done++;
            done_at = k;
         end
         if (s_plot) begin
            if (k < 2 || k > p + 1) plot_bad++;
            obs_q.push_back((int'(s_x) << 16) | (int'(s_y) << 8) | int'(s_col));
            if (!b) begin
               last_x = s_x;
               last_y = s_y;
               last_c = s_col;
            end
         end else if (!b && (s_x !== last_x || s_y !== last_y || s_col !== last_c)) begin
            hold_bad++;
         end
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] != exp_q[i]) mism++;
      check_eq({nm, ".addr_seq"}, addr_bad, 0);
      check_eq({nm, ".busy"}, busy_bad, 0);
      check_eq({nm, ".done_cnt"}, n_done, 1);
      check_eq({nm, ".done_at"}, done_at, p + 2);
      check_eq({nm, ".plot_window"}, plot_bad, 0);
      check_eq({nm, ".plot_cnt"}, obs_q.size(), exp_q.size());
      check_eq({nm, ".plot_data"}, mism, 0);
      check_eq({nm, ".hold"}, hold_bad, 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      start_a = 1'b0;
      start_b = 1'b0;
      x0 = '0;
      y0 = '0;
      frame = '0;
      sel_b = 1'b0;
      resetn = 1'b0;
      last_x = '0;
      last_y = '0;
      last_c = '0;
      // Frame 1 is a 0/5 checkerboard; the others are random and include transparent 0s.
      for (int i = 0; i < 256; i++) begin
         int f, r, c;
         f = i / 64;
         r = (i % 64) / 8;
         c = i % 8;
         if (f == 1) rom_a[i] = ((r + c) % 2 == 1) ? 3'd5 : 3'd0;
         else rom_a[i] = 3'($urandom_range(0, 7));
      end
      for (int i = 0; i < 32768; i++) rom_b[i] = 3'(i % 7);

      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_a", {s_addr, s_x, s_y, s_col, s_plot, s_busy, s_done}, 0);
      sel_b = 1'b1;
      #1;
      check_eq("reset_b", {s_addr, s_x, s_y, s_col, s_plot, s_busy, s_done}, 0);
      resetn = 1'b1;
      @(negedge clk);

      draw("full_screen", 1'b1, 8'd0, 7'd0, 4'd0, 1'b0, 0);
      draw("frame2", 1'b0, 8'd10, 7'd20, 4'd2, 1'b0, 0);
      draw("corner_clip", 1'b0, 8'd156, 7'd116, 4'd3, 1'b0, 0);
      draw("checker", 1'b0, 8'd30, 7'd40, 4'd1, 1'b0, 0);
      draw("mid_start", 1'b0, 8'd50, 7'd60, 4'd0, 1'b1, 0);
      draw("bad_frame", 1'b0, 8'd70, 7'd10, 4'd9, 1'b0, 0);
      draw("rst_abort", 1'b0, 8'd5, 7'd5, 4'd2, 1'b0, 30);
      draw("after_rst", 1'b0, 8'd0, 7'd0, 4'd0, 1'b0, 0);
      for (int n = 0; n < 8; n++) begin
         draw("rand", 1'b0, 8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
